// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// mlp_pkg : shared element type and argmax FSM states for the MLP datapath
// Revision: 1.0
// ============================================================================
package mlp_pkg;

  typedef logic [7:0] mlp_elem_t;

  typedef enum logic [1:0] {
    ARGMAX_IDLE = 2'd0,
    ARGMAX_SCAN = 2'd1,
    ARGMAX_DONE = 2'd2
  } argmax_state_e;

endpackage : mlp_pkg
`default_nettype wire

// File: rtl/mlp_argmax.sv
`default_nettype none
// ============================================================================
// mlp_argmax : sequential argmax over a captured class-score vector
// Revision: 1.0
// ============================================================================
module mlp_argmax
  import mlp_pkg::*;
#(
  parameter type T  = mlp_elem_t,
  parameter int  D2 = 8,
  localparam int IW = (D2 > 1) ? $clog2(D2) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  T              din [D2],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] class_idx,
  output T              class_score
);

  argmax_state_e state, state_nx;
  logic [IW-1:0] cnt;
  T              vec_q [D2];
  T              best;
  logic [IW-1:0] best_idx;

  T              cur;
  logic          last;
  logic          take;
  T              best_nx;
  logic [IW-1:0] best_idx_nx;

  // Reset gating keeps the stage from advertising readiness while held in reset.
  assign in_ready  = (state == ARGMAX_IDLE) && rst_n;
  assign out_valid = (state == ARGMAX_DONE);

  always_comb begin
    state_nx    = state;
    cur         = '0;
    for (int i = 0; i < D2; i++) begin
      if (cnt == IW'(i)) cur = vec_q[i];
    end
    last        = (cnt == IW'(D2 - 1));
    // Strict compare: on ties the earlier (lower) index is kept.
    take        = (cnt == '0) || (cur > best);
    best_nx     = take ? cur : best;
    best_idx_nx = take ? cnt : best_idx;
    case (state)
      ARGMAX_IDLE: if (in_valid) state_nx = ARGMAX_SCAN;
      ARGMAX_SCAN: if (last)     state_nx = ARGMAX_DONE;
      ARGMAX_DONE: if (out_ready) state_nx = ARGMAX_IDLE;
      default:                   state_nx = ARGMAX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARGMAX_IDLE;
      cnt         <= '0;
      best        <= '0;
      best_idx    <= '0;
      class_idx   <= '0;
      class_score <= '0;
      for (int i = 0; i < D2; i++) vec_q[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ARGMAX_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < D2; i++) vec_q[i] <= din[i];
            cnt <= '0;
          end
        end
        ARGMAX_SCAN: begin
          best     <= best_nx;
          best_idx <= best_idx_nx;
          if (last) begin
            class_idx   <= best_idx_nx;
            class_score <= best_nx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : mlp_argmax
`default_nettype wire

// File: tb/tb_mlp_argmax.sv
`default_nettype none
// ============================================================================
// tb_mlp_argmax : directed and random checks of mlp_argmax against a reference
// Revision: 1.0
// ============================================================================
module tb_mlp_argmax;
  import mlp_pkg::*;

  localparam int D2 = 4;
  localparam int IW = (D2 > 1) ? $clog2(D2) : 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  mlp_elem_t     din [D2];
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] class_idx;
  mlp_elem_t     class_score;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mlp_argmax #(.T(mlp_elem_t), .D2(D2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready),
    .class_idx(class_idx), .class_score(class_score)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: largest value, first position where it occurs.
  task automatic ref_argmax(input mlp_elem_t v [D2], output int idx, output int score);
    int mx = 0;
    for (int i = 0; i < D2; i++) if (int'(v[i]) > mx) mx = int'(v[i]);
    idx = -1;
    for (int i = 0; i < D2; i++) if (idx < 0 && int'(v[i]) == mx) idx = i;
    score = mx;
  endtask

  task automatic scramble_din();
    for (int i = 0; i < D2; i++) din[i] = mlp_elem_t'($urandom);
  endtask

  task automatic do_vec(input mlp_elem_t v [D2], input int hold);
    int ei, es, n;
    ref_argmax(v, ei, es);
    chk("ready_idle", 32'(in_ready), 32'd1);
    din       = v;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 4 * D2 + 8) begin
      chk("ready_scan", 32'(in_ready), 32'd0);
      scramble_din();
      in_valid = 1'($urandom);
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'(D2));
    chk("class_idx", 32'(class_idx), 32'(ei));
    chk("class_score", 32'(class_score), 32'(es));
    for (int h = 0; h < hold; h++) begin
      scramble_din();
      in_valid = 1'($urandom);
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_idx", 32'(class_idx), 32'(ei));
      chk("hold_score", 32'(class_score), 32'(es));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    mlp_elem_t v [D2];
    int t0, gap, seen, cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < D2; i++) din[i] = '0;
    #23;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_score", 32'(class_score), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    v = '{8'd3, 8'd9, 8'd2, 8'd7};        do_vec(v, 0);
    v = '{8'd5, 8'd5, 8'd5, 8'd5};        do_vec(v, 0);
    v = '{8'd0, 8'd0, 8'd0, 8'd200};      do_vec(v, 0);
    v = '{8'h7F, 8'h80, 8'h00, 8'h00};    do_vec(v, 0);
    v = '{8'd10, 8'd40, 8'd40, 8'd1};     do_vec(v, 10);
    tick();
    chk("bp_nothing_captured", 32'(in_ready), 32'd1);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < D2; i++)
        v[i] = (k % 3 == 0) ? mlp_elem_t'($urandom_range(0, 3)) : mlp_elem_t'($urandom);
      do_vec(v, (k % 5 == 4) ? int'($urandom_range(1, 4)) : 0);
    end

    // Reset during SCAN with cnt at 2
    v = '{8'd9, 8'd8, 8'd7, 8'd6};
    din = v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    #4;
    rst_n = 1'b1;
    tick();
    chk("midrst_rel_ready", 32'(in_ready), 32'd1);
    chk("midrst_no_result", 32'(out_valid), 32'd0);
    v = '{8'd1, 8'd2, 8'd3, 8'd4};        do_vec(v, 0);

    // Back-to-back with in_valid and out_ready held high
    v = '{8'd11, 8'd33, 8'd22, 8'd33};
    din = v; in_valid = 1'b1; out_ready = 1'b1;
    t0 = -1; seen = 0; cyc = 0;
    while (seen < 4 && cyc < 20 * (D2 + 2)) begin
      tick();
      cyc++;
      if (out_valid) begin
        chk("b2b_idx", 32'(class_idx), 32'd1);
        if (t0 >= 0) begin
          gap = cyc - t0;
          chk("b2b_period", 32'(gap), 32'(D2 + 2));
        end
        t0 = cyc;
        seen++;
      end
    end
    chk("b2b_results", 32'(seen), 32'd4);
    in_valid = 1'b0;
    repeat (D2 + 3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mlp_argmax
`default_nettype wire
